pulse_stretch: RTL and testbench

Converts single-cycle event pulses into clean, well-separated level pulses: each accepted input pulse yields exactly one high window of HIGH_CYC cycles followed by at least LOW_CYC low cycles. Pulses that arrive while a window is in progress are queued in a saturating pending counter, so none are lost up to PEND_MAX. The block sits between pulse-producing logic (UART strobes, done flags) and slower or level-sensitive consumers. Its output is guaranteed to present one rising edge per accepted event to a downstream rising-edge pulse generator.

---
 rtl/pulse_stretch.sv | 140 ++++++++++++++
 tb/tb_pulse_stretch.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pulse_stretch.sv
// pulse_stretch: turns single-cycle event pulses into fixed-width level windows
// separated by a minimum low gap, queueing events that arrive while a window runs.
module pulse_stretch #(
    parameter int unsigned HIGH_CYC = 4,
    parameter int unsigned LOW_CYC  = 2,
    parameter int unsigned PEND_MAX = 3,
    parameter int unsigned PEND_W   = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              PulseSig,
    input  logic              ClrOvf,
    output logic              LvlSig,
    output logic              Busy,
    output logic [PEND_W-1:0] PendCnt,
    output logic              Overflow
);

    localparam int unsigned CNT_MAX = (HIGH_CYC > LOW_CYC) ? (HIGH_CYC - 1) : (LOW_CYC - 1);
    localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(HIGH_CYC - 1);
    localparam logic [CNT_W-1:0]  LOW_LOAD  = CNT_W'(LOW_CYC - 1);
    localparam logic [PEND_W-1:0] PEND_ZERO = {PEND_W{1'b0}};
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
    localparam logic [PEND_W-1:0] PEND_FULL = PEND_W'(PEND_MAX);
    localparam logic [PEND_W:0]   EFF_ZERO  = {(PEND_W + 1){1'b0}};
    localparam logic [PEND_W:0]   EFF_ONE   = (PEND_W + 1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_s;
    logic [PEND_W-1:0]  pend_s;
    logic [PEND_W:0]    eff_s;
    logic               inc_s;
    logic               drop_s;
    logic               ovf_s;

    // Next-state, window counter, pending queue and overflow decisions.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        pend_s  = PendCnt;
        eff_s   = EFF_ZERO;
        inc_s   = 1'b0;
        drop_s  = 1'b0;
        ovf_s   = Overflow;

        case (state_r)
            ST_IDLE: begin
                if (PulseSig) begin
                    state_s = ST_HIGH;
                    cnt_s   = HIGH_LOAD;
                end else begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                end
            end
            ST_HIGH: begin
                inc_s = PulseSig;
                if (cnt_r == CNT_ZERO) begin
                    state_s = ST_LOW;
                    cnt_s   = LOW_LOAD;
                end else begin
                    state_s = ST_HIGH;
                    cnt_s   = cnt_r - CNT_ONE;
                end
            end
            ST_LOW: begin
                // Last low cycle: a pulse arriving now is consumed directly with the queue.
                if (cnt_r == CNT_ZERO) begin
                    eff_s = {1'b0, PendCnt} + {{PEND_W{1'b0}}, PulseSig};
                    if (eff_s != EFF_ZERO) begin
                        state_s = ST_HIGH;
                        cnt_s   = HIGH_LOAD;
                        pend_s  = PEND_W'(eff_s - EFF_ONE);
                    end else begin
                        state_s = ST_IDLE;
                        cnt_s   = CNT_ZERO;
                    end
                end else begin
                    state_s = ST_LOW;
                    cnt_s   = cnt_r - CNT_ONE;
                    inc_s   = PulseSig;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
                pend_s  = PEND_ZERO;
            end
        endcase

        if (inc_s && (PendCnt == PEND_FULL)) begin
            drop_s = 1'b1;
        end else if (inc_s) begin
            pend_s = PendCnt + PEND_ONE;
        end else begin
            drop_s = 1'b0;
        end

        // A drop in the same cycle as a clear keeps the flag set.
        if (drop_s) begin
            ovf_s = 1'b1;
        end else if (ClrOvf) begin
            ovf_s = 1'b0;
        end else begin
            ovf_s = Overflow;
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= CNT_ZERO;
            LvlSig   <= 1'b0;
            Busy     <= 1'b0;
            PendCnt  <= PEND_ZERO;
            Overflow <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            LvlSig   <= (state_s == ST_HIGH);
            Busy     <= (state_s != ST_IDLE);
            PendCnt  <= pend_s;
            Overflow <= ovf_s;
        end
    end

endmodule

// File: tb/tb_pulse_stretch.sv
// Directed scoreboard bench for pulse_stretch with HIGH_CYC=4, LOW_CYC=2, PEND_MAX=3.
module tb_pulse_stretch;

    logic       Clk;
    logic       Reset;
    logic       PulseSig;
    logic       ClrOvf;
    logic       LvlSig;
    logic       Busy;
    logic [1:0] PendCnt;
    logic       Overflow;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       lvl;
        logic       busy;
        logic [1:0] pend;
        logic       ovf;
    } exp_t;

    exp_t exp_q[$];

    pulse_stretch #(
        .HIGH_CYC(4),
        .LOW_CYC (2),
        .PEND_MAX(3),
        .PEND_W  (2)
    ) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .PulseSig(PulseSig),
        .ClrOvf  (ClrOvf),
        .LvlSig  (LvlSig),
        .Busy    (Busy),
        .PendCnt (PendCnt),
        .Overflow(Overflow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic bit in_rng(input int c, input int lo, input int hi);
        return (c >= lo) && (c <= hi);
    endfunction

    // Expected outputs of a full saturating burst whose first pulse is at r=0.
    function automatic exp_t burst_exp(input int r);
        exp_t e;
        e = '0;
        if (in_rng(r, 1, 24)) begin
            e.busy = 1'b1;
            e.lvl  = in_rng(r, 1, 4) || in_rng(r, 7, 10) || in_rng(r, 13, 16) || in_rng(r, 19, 22);
            if (r == 2)                 e.pend = 2'd1;
            else if (r == 3)            e.pend = 2'd2;
            else if (in_rng(r, 4, 6))   e.pend = 2'd3;
            else if (in_rng(r, 7, 12))  e.pend = 2'd2;
            else if (in_rng(r, 13, 18)) e.pend = 2'd1;
            else                        e.pend = 2'd0;
        end
        return e;
    endfunction

    function automatic exp_t expect_at(input int id, input int c);
        exp_t e;
        e = '0;
        case (id)
            2: begin
                e.lvl  = in_rng(c, 11, 14);
                e.busy = in_rng(c, 11, 16);
            end
            3: begin
                e.lvl  = in_rng(c, 11, 14) || in_rng(c, 17, 20) || in_rng(c, 23, 26);
                e.busy = in_rng(c, 11, 28);
                if (c == 13)                e.pend = 2'd1;
                else if (in_rng(c, 14, 16)) e.pend = 2'd2;
                else if (in_rng(c, 17, 22)) e.pend = 2'd1;
                else                        e.pend = 2'd0;
            end
            4: begin
                e.lvl  = in_rng(c, 11, 14) || in_rng(c, 17, 20);
                e.busy = in_rng(c, 11, 22);
            end
            5: begin
                if (c < 38) e = burst_exp(c - 10);
                else        e = burst_exp(c - 40);
                e.ovf = in_rng(c, 15, 36) || (c >= 45);
            end
            6: begin
                e.lvl  = in_rng(c, 11, 13);
                e.busy = in_rng(c, 11, 13);
                if (c == 12)      e.pend = 2'd1;
                else if (c == 13) e.pend = 2'd2;
                else              e.pend = 2'd0;
            end
            default: e = '0;
        endcase
        return e;
    endfunction

    task automatic drive(input int id, input int c);
        Reset    = (c == 0);
        PulseSig = 1'b0;
        ClrOvf   = 1'b0;
        case (id)
            1: begin
                Reset    = (c < 2);
                PulseSig = (c == 0);
            end
            2: PulseSig = (c == 10);
            3: PulseSig = (c == 10) || (c == 12) || (c == 13);
            4: PulseSig = (c == 10) || (c == 16);
            5: begin
                PulseSig = in_rng(c, 10, 15) || in_rng(c, 40, 45);
                ClrOvf   = (c == 36) || (c == 45);
            end
            6: begin
                PulseSig = in_rng(c, 10, 12);
                Reset    = (c == 0) || (c == 13);
            end
            default: PulseSig = 1'b0;
        endcase
    endtask

    task automatic run_test(input int id, input string tag, input int ncyc);
        exp_t e;
        for (int c = 0; c < ncyc; c++) begin
            drive(id, c);
            exp_q.push_back(expect_at(id, c + 1));
            @(posedge Clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            assert (LvlSig === e.lvl) else begin
                errors++;
                $error("FAIL %s lvl cycle %0d: observed %b expected %b", tag, c + 1, LvlSig, e.lvl);
            end
            checks++;
            assert (Busy === e.busy) else begin
                errors++;
                $error("FAIL %s busy cycle %0d: observed %b expected %b", tag, c + 1, Busy, e.busy);
            end
            checks++;
            assert (PendCnt === e.pend) else begin
                errors++;
                $error("FAIL %s pend cycle %0d: observed %0d expected %0d", tag, c + 1, PendCnt, e.pend);
            end
            checks++;
            assert (Overflow === e.ovf) else begin
                errors++;
                $error("FAIL %s ovf cycle %0d: observed %b expected %b", tag, c + 1, Overflow, e.ovf);
            end
        end
    endtask

    initial begin
        Reset    = 1'b1;
        PulseSig = 1'b0;
        ClrOvf   = 1'b0;
        run_test(1, "reset",     5);
        run_test(2, "single",    20);
        run_test(3, "queued",    32);
        run_test(4, "last_low",  26);
        run_test(5, "overflow",  68);
        run_test(6, "mid_reset", 30);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
